// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte requesters share one UART
// transmitter. One grant per transfer; each transfer walks through
// IDLE -> START -> WAIT_BUSY -> WAIT_DONE, with a bounded wait for the
// transmitter to acknowledge the start pulse by raising txBusy.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 16,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W       = $clog2(BUSY_TIMEOUT) + 1
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic                          txStart,
  output logic [DATA_WIDTH-1:0]         txData,
  input  logic                          txBusy,
  output logic [ID_W-1:0]               grantId,
  output logic                          idle,
  output logic                          timeoutErr
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [NUM_REQ-1:0]    r_ready;
  logic                  r_start;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_cnt;

  logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_winner;
  logic                  w_found;
  logic [ID_W-1:0]       w_next_ptr;

  // Unpack the flat request data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_bytes[g] = reqData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && reqValid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    w_next_ptr = ID_W'((32'(w_winner) + 1) % NUM_REQ);
  end

  // Transfer FSM with registered outputs; start/ready/timeout are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_ready    <= '0;
      r_start    <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ready   <= '0;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!txBusy && w_found) begin
            r_tx_data          <= w_bytes[w_winner];
            r_grant_id         <= w_winner;
            r_ready[w_winner]  <= 1'b1;
            r_start            <= 1'b1;
            r_ptr              <= w_next_ptr;
            r_state            <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (txBusy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!txBusy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reqReady   = r_ready;
  assign txStart    = r_start;
  assign txData     = r_tx_data;
  assign grantId    = r_grant_id;
  assign idle       = (r_state == S_IDLE);
  assign timeoutErr = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of single-cycle vectors with
// hand-computed outputs, plus sequences for round-robin order, busy timeout
// and reset in the middle of a transfer.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BT = 16;

  logic           clk = 1'b0;
  logic           rstN;
  logic [NR-1:0]  reqValid;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]  reqReady;
  logic           txStart;
  logic [DW-1:0]  txData;
  logic           txBusy;
  logic [1:0]     grantId;
  logic           idle;
  logic           timeoutErr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .txStart    (txStart),
    .txData     (txData),
    .txBusy     (txBusy),
    .grantId    (grantId),
    .idle       (idle),
    .timeoutErr (timeoutErr)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] rv;
    logic       busy;
    logic [3:0] rdy;
    logic       st;
    logic [7:0] d;
    logic [1:0] g;
    logic       idl;
    logic       te;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(logic r, logic [3:0] rv, logic b, logic [3:0] rdy,
                              logic st, logic [7:0] d, logic [1:0] g, logic idl, logic te);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.busy = b; v.rdy = rdy; v.st = st;
    v.d = d; v.g = g; v.idl = idl; v.te = te;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] outs();
    return {15'b0, reqReady, txStart, txData, grantId, idle, timeoutErr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0; reqValid = '0; txBusy = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0; reqValid = '0; txBusy = 1'b0;
    // req0=11 req1=22 req2=A5 req3=44
    reqData = 32'h44A52211;

    //   rstN rv      busy  ready   st  data   gid idle te
    add(0, 4'b0000, 0,   4'b0000, 0, 8'h00, 0, 1, 0); // reset
    add(1, 4'b0100, 0,   4'b0100, 1, 8'hA5, 2, 0, 0); // single grant -> START
    add(1, 4'b0100, 0,   4'b0000, 0, 8'hA5, 2, 0, 0); // WAIT_BUSY, reqValid ignored
    add(1, 4'b0000, 0,   4'b0000, 0, 8'hA5, 2, 0, 0); // still WAIT_BUSY
    add(1, 4'b0000, 1,   4'b0000, 0, 8'hA5, 2, 0, 0); // -> WAIT_DONE
    add(1, 4'b1111, 1,   4'b0000, 0, 8'hA5, 2, 0, 0); // requests ignored
    add(1, 4'b0000, 0,   4'b0000, 0, 8'hA5, 2, 1, 0); // -> IDLE, data held
    add(1, 4'b0001, 1,   4'b0000, 0, 8'hA5, 2, 1, 0); // blocked by txBusy
    add(1, 4'b0001, 1,   4'b0000, 0, 8'hA5, 2, 1, 0);
    add(1, 4'b0001, 0,   4'b0001, 1, 8'h11, 0, 0, 0); // ptr=3 wraps to 0
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h11, 0, 0, 0);
    add(1, 4'b0000, 1,   4'b0000, 0, 8'h11, 0, 0, 0);
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h11, 0, 1, 0);
    add(1, 4'b1000, 1,   4'b0000, 0, 8'h11, 0, 1, 0); // blocked
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h11, 0, 1, 0); // dropped: no grant
    add(1, 4'b1010, 0,   4'b0010, 1, 8'h22, 1, 0, 0); // ptr=1 -> req1
    add(1, 4'b1000, 0,   4'b0000, 0, 8'h22, 1, 0, 0);
    add(1, 4'b0000, 1,   4'b0000, 0, 8'h22, 1, 0, 0);
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h22, 1, 1, 0);
    add(1, 4'b1001, 0,   4'b1000, 1, 8'h44, 3, 0, 0); // ptr=2 -> req3
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h44, 3, 0, 0);
    add(1, 4'b0000, 1,   4'b0000, 0, 8'h44, 3, 0, 0);
    add(1, 4'b0000, 0,   4'b0000, 0, 8'h44, 3, 1, 0);

    foreach (tbl[i]) begin
      rstN     = tbl[i].rst_n;
      reqValid = tbl[i].rv;
      txBusy   = tbl[i].busy;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {15'b0, tbl[i].rdy, tbl[i].st, tbl[i].d, tbl[i].g, tbl[i].idl, tbl[i].te});
    end

    // Round-robin with all requesters held: 0,1,2,3,0
    do_reset();
    reqValid = 4'b1111;
    for (int unsigned t = 0; t < 5; t++) begin
      int unsigned waited;
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!txStart && waited < 10);
      check("rr_start_seen", 32'(txStart), 32'd1);
      check($sformatf("rr_gid%0d", t), 32'(grantId), t % 4);
      check($sformatf("rr_ready%0d", t), 32'(reqReady), 32'(1) << (t % 4));
      txBusy = 1'b1;
      tick();
      tick();
      txBusy = 1'b0;
      waited = 0;
      while (!idle && waited < 10) begin
        tick();
        waited++;
      end
      check("rr_back_idle", 32'(idle), 32'd1);
    end

    // Busy timeout: txBusy never rises after the grant
    do_reset();
    reqValid = 4'b0100;
    tick();
    check("to_grant", {24'b0, reqReady, txStart, grantId, idle}, {24'b0, 4'b0100, 1'b1, 2'd2, 1'b0});
    reqValid = '0;
    tick();
    begin
      int unsigned cyc;
      cyc = 0;
      while (!timeoutErr && cyc < BT + 5) begin
        tick();
        cyc++;
      end
      check("to_cycles", cyc, BT);
    end
    check("to_idle", 32'(idle), 32'd1);
    tick();
    check("to_pulse_once", 32'(timeoutErr), 32'd0);
    reqValid = 4'b1111;
    tick();
    check("to_ptr_adv", {28'b0, reqReady}, {28'b0, 4'b1000});

    // Reset during WAIT_DONE aborts the transfer
    do_reset();
    reqValid = 4'b0010;
    tick();
    check("mr_grant", 32'(grantId), 32'd1);
    reqValid = '0;
    txBusy   = 1'b1;
    tick();
    tick();
    check("mr_in_transfer", 32'(idle), 32'd0);
    rstN = 1'b0;
    tick();
    check("mr_outputs", outs(), 32'h0000_0002);
    rstN     = 1'b1;
    txBusy   = 1'b0;
    reqValid = 4'b1010;
    tick();
    check("mr_first_grant", {24'b0, reqReady, txStart, grantId, 1'b0}, {24'b0, 4'b0010, 1'b1, 2'd1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
